immediate_gen_pipe: RTL

Parametrised, registered successor to the combinational immediate selector. It sits between the decode and execute stages. It decodes RV32I/RV64I immediates for a configurable XLEN and holds them in a 2-entry skid buffer with valid/ready handshakes on both sides. Each immediate travels with a tag (PC or ROB index) and an illegal-select flag. FLUSH discards in-flight entries.

---
 rtl/immediate_gen_pipe.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/immediate_gen_pipe.sv
// immediate_gen_pipe: RV32I/RV64I immediate decoder feeding a 2-entry skid
// buffer with valid/ready on both sides. Each entry carries a sideband tag and
// an illegal-select flag. FLUSH discards all buffered entries.
// Optional feature macro: IMMGEN_ZIMM_EN (SELECT[2:0]=110 decodes CSR zimm).
module immediate_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [31:0]      INSTRUCTION,
    input  logic [3:0]       SELECT,
    input  logic [TAG_W-1:0] IN_TAG,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  OUTPUT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_ILLEGAL
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   head_imm_q, head_imm_d, tail_imm_q, tail_imm_d;
    logic [TAG_W-1:0]  head_tag_q, head_tag_d, tail_tag_q, tail_tag_d;
    logic              head_ill_q, head_ill_d, tail_ill_q, tail_ill_d;

    logic [31:0]        raw_z;
    logic signed [31:0] raw_s;
    logic               force_zx;
    logic               dec_ill;
    logic [XLEN-1:0]    sext_v;
    logic [XLEN-1:0]    zext_v;
    logic [XLEN-1:0]    dec_imm;
    logic               push, pop;

    // Opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^INSTRUCTION[6:0];

    // Decode the immediate from the raw instruction into zero- and sign-extended forms.
    always_comb begin
        raw_z    = '0;
        raw_s    = '0;
        force_zx = 1'b0;
        dec_ill  = 1'b0;
        case (SELECT[2:0])
            3'b000: begin
                raw_z = {INSTRUCTION[31:12], 12'b0};
                raw_s = $signed({INSTRUCTION[31:12], 12'b0});
            end
            3'b001: begin
                raw_z = {11'b0, INSTRUCTION[31], INSTRUCTION[19:12], INSTRUCTION[20],
                         INSTRUCTION[30:21], 1'b0};
                raw_s = $signed({{11{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[19:12],
                                 INSTRUCTION[20], INSTRUCTION[30:21], 1'b0});
            end
            3'b010: begin
                raw_z = {20'b0, INSTRUCTION[31:20]};
                raw_s = $signed({{20{INSTRUCTION[31]}}, INSTRUCTION[31:20]});
            end
            3'b011: begin
                raw_z = {19'b0, INSTRUCTION[31], INSTRUCTION[7], INSTRUCTION[30:25],
                         INSTRUCTION[11:8], 1'b0};
                raw_s = $signed({{19{INSTRUCTION[31]}}, INSTRUCTION[31], INSTRUCTION[7],
                                 INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0});
            end
            3'b100: begin
                raw_z = {20'b0, INSTRUCTION[31:25], INSTRUCTION[11:7]};
                raw_s = $signed({{20{INSTRUCTION[31]}}, INSTRUCTION[31:25], INSTRUCTION[11:7]});
            end
            3'b101: begin
                force_zx = 1'b1;
                if (XLEN == 32) raw_z = {27'b0, INSTRUCTION[24:20]};
                else            raw_z = {26'b0, INSTRUCTION[25:20]};
            end
`ifdef IMMGEN_ZIMM_EN
            3'b110: begin
                force_zx = 1'b1;
                raw_z    = {27'b0, INSTRUCTION[19:15]};
            end
`endif
            default: dec_ill = 1'b1;
        endcase
    end

    // Widen to XLEN and pick the extension mode; illegal selects yield zero.
    always_comb begin
        sext_v = XLEN'(raw_s);
        zext_v = XLEN'(raw_z);
        if (dec_ill)                      dec_imm = '0;
        else if (SELECT[3] || force_zx)   dec_imm = zext_v;
        else                              dec_imm = sext_v;
    end

    assign IN_READY  = (state_q != FULL);
    assign OUT_VALID = (state_q != EMPTY);
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;

    // Head registers drive the outputs, masked to zero while nothing is buffered.
    assign OUTPUT      = OUT_VALID ? head_imm_q : '0;
    assign OUT_TAG     = OUT_VALID ? head_tag_q : '0;
    assign OUT_ILLEGAL = OUT_VALID & head_ill_q;

    // Occupancy next-state and data movement; FLUSH overrides push and pop.
    always_comb begin
        state_d    = state_q;
        head_imm_d = head_imm_q;
        head_tag_d = head_tag_q;
        head_ill_d = head_ill_q;
        tail_imm_d = tail_imm_q;
        tail_tag_d = tail_tag_q;
        tail_ill_d = tail_ill_q;
        if (FLUSH) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        head_imm_d = dec_imm;
                        head_tag_d = IN_TAG;
                        head_ill_d = dec_ill;
                        state_d    = HALF;
                    end
                end
                HALF: begin
                    if (push && !pop) begin
                        tail_imm_d = dec_imm;
                        tail_tag_d = IN_TAG;
                        tail_ill_d = dec_ill;
                        state_d    = FULL;
                    end else if (push && pop) begin
                        head_imm_d = dec_imm;
                        head_tag_d = IN_TAG;
                        head_ill_d = dec_ill;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_imm_d = tail_imm_q;
                        head_tag_d = tail_tag_q;
                        head_ill_d = tail_ill_q;
                        state_d    = HALF;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State and data registers with asynchronous clear.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= EMPTY;
            head_imm_q <= '0;
            head_tag_q <= '0;
            head_ill_q <= 1'b0;
            tail_imm_q <= '0;
            tail_tag_q <= '0;
            tail_ill_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_imm_q <= head_imm_d;
            head_tag_q <= head_tag_d;
            head_ill_q <= head_ill_d;
            tail_imm_q <= tail_imm_d;
            tail_tag_q <= tail_tag_d;
            tail_ill_q <= tail_ill_d;
        end
    end

endmodule
